// File: rtl/traffic_sensor_model.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_sensor_model
//  Description : Two-street vehicle queue model for a traffic light controller.
//                Each street keeps a saturating queue counter fed by arrival
//                pulses and drained by timed departures while its light is
//                GREEN. The sensor outputs Ta/Tb report non-empty queues.
//                Sticky flags record queue overflow, conflicting lights
//                (both streets non-RED) and illegal light encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_sensor_model #(
    parameter int QW         = 4,
    parameter int DEPART_CYC = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_a,
    input  logic          arrive_b,
    input  logic [1:0]    La,
    input  logic [1:0]    Lb,
    input  logic          clr_flags,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] qa_count,
    output logic [QW-1:0] qb_count,
    output logic [1:0]    overflow,
    output logic          conflict,
    output logic          illegal
);

    // Light encoding
    localparam logic [1:0] c_RED    = 2'b00;
    localparam logic [1:0] c_GREEN  = 2'b10;
    localparam logic [1:0] c_ILLEGAL = 2'b11;

    // Queue saturation value and the timer value on which a departure occurs
    localparam logic [QW-1:0] c_QMAX        = {QW{1'b1}};
    localparam logic [3:0]    c_DEPART_LAST = 4'(DEPART_CYC - 1);

    // Per-street inputs gathered into buses so both streets share one generate body
    logic [1:0]      w_arrive_bus;
    logic [3:0]      w_light_bus;
    logic [2*QW-1:0] w_queue_bus;
    logic [1:0]      w_ovf_set_bus;

    assign w_arrive_bus = {arrive_b, arrive_a};
    assign w_light_bus  = {Lb, La};

    // Sticky flag registers
    logic [1:0] r_overflow;
    logic       r_conflict;
    logic       r_illegal;

    // Flag set conditions for the current cycle
    logic w_conflict_set;
    logic w_illegal_set;

    assign w_conflict_set = (La != c_RED) && (Lb != c_RED);
    assign w_illegal_set  = (La == c_ILLEGAL) || (Lb == c_ILLEGAL);

    // ------------------------------------------------------------------------
    // One independent queue + departure timer per street (index 0 = A, 1 = B)
    // ------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_street
            logic [QW-1:0] r_queue;
            logic [3:0]    r_timer;
            logic [QW-1:0] w_queue_nxt;
            logic [3:0]    w_timer_nxt;
            logic          w_arrive;
            logic          w_green;
            logic          w_active;
            logic          w_depart;
            logic          w_ovf_set;

            assign w_arrive = w_arrive_bus[gi];
            assign w_green  = (w_light_bus[gi*2 +: 2] == c_GREEN);

            // Timer only runs while the light is GREEN and somebody is waiting;
            // any other cycle throws away partial progress.
            assign w_active = w_green && (r_queue != '0);
            assign w_depart = w_active && (r_timer == c_DEPART_LAST);

            // Next-state for timer and queue; a simultaneous arrival and
            // departure cancel, and an arrival into a full queue is dropped.
            always_comb begin
                w_timer_nxt = 4'd0;
                w_queue_nxt = r_queue;
                w_ovf_set   = 1'b0;

                if (w_active && !w_depart) begin
                    w_timer_nxt = r_timer + 4'd1;
                end

                if (w_arrive && !w_depart) begin
                    if (r_queue == c_QMAX) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_queue_nxt = r_queue + 1'b1;
                    end
                end else if (w_depart && !w_arrive) begin
                    w_queue_nxt = r_queue - 1'b1;
                end
            end

            // Queue and timer state; reset discards any pending departure
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_queue <= '0;
                    r_timer <= 4'd0;
                end else begin
                    r_queue <= w_queue_nxt;
                    r_timer <= w_timer_nxt;
                end
            end

            assign w_queue_bus[gi*QW +: QW] = r_queue;
            assign w_ovf_set_bus[gi]         = w_ovf_set;
        end
    endgenerate

    // Sticky flags: clear request applies first, so a set in the same cycle wins
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_overflow <= 2'b00;
            r_conflict <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_overflow <= (clr_flags ? 2'b00 : r_overflow) | w_ovf_set_bus;
            r_conflict <= (clr_flags ? 1'b0  : r_conflict) | w_conflict_set;
            r_illegal  <= (clr_flags ? 1'b0  : r_illegal)  | w_illegal_set;
        end
    end

    // Outputs are decoded straight from registered state
    assign qa_count = w_queue_bus[QW-1:0];
    assign qb_count = w_queue_bus[2*QW-1:QW];
    assign Ta       = (w_queue_bus[QW-1:0] != '0);
    assign Tb       = (w_queue_bus[2*QW-1:QW] != '0);
    assign overflow = r_overflow;
    assign conflict = r_conflict;
    assign illegal  = r_illegal;

endmodule
`default_nettype wire

// File: doc/traffic_sensor_model.md
TRAFFIC_SENSOR_MODEL -- requirements
Module: traffic_sensor_model

Interface
REQ-001 SHALL have parameter QW, default 4: queue counter width; max count QMAX = 2^QW-1.
REQ-002 SHALL have parameter DEPART_CYC, default 3: green cycles per vehicle departure, legal range 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port arrive_a  input  1  one-cycle pulse, one vehicle joins street A queue.
REQ-006 SHALL have port arrive_b  input  1  one-cycle pulse, one vehicle joins street B queue.
REQ-007 SHALL have port La  input  2  street A light: 00 RED, 01 YELLOW, 10 GREEN, 11 illegal.
REQ-008 SHALL have port Lb  input  2  street B light, same encoding as La.
REQ-009 SHALL have port clr_flags  input  1  one-cycle pulse, clears sticky flags.
REQ-010 SHALL have port Ta  output  1  street A sensor, high when queue A non-empty.
REQ-011 SHALL have port Tb  output  1  street B sensor, high when queue B non-empty.
REQ-012 SHALL have port qa_count  output  QW  vehicles queued on A.
REQ-013 SHALL have port qb_count  output  QW  vehicles queued on B.
REQ-014 SHALL have port overflow  output  2  sticky; bit0 A, bit1 B, arrival dropped at QMAX.
REQ-015 SHALL have port conflict  output  1  sticky; La and Lb both non-RED in the same cycle.
REQ-016 SHALL have port illegal  output  1  sticky; La or Lb equals 11.

Function
REQ-017 Per street, SHALL keep a QW-bit queue register and a 4-bit departure timer, independent of the other street.
REQ-018 Timer SHALL increment each cycle that the light is GREEN and the queue is non-zero. It SHALL clear to 0 in every other cycle.
REQ-019 When timer == DEPART_CYC-1 and the light is GREEN with queue non-zero, the timer SHALL return to 0 and one departure SHALL occur that cycle.
REQ-020 YELLOW, RED and 11 SHALL all inhibit departures. The timer SHALL clear on the first non-GREEN cycle, so partial progress is lost.
REQ-021 Queue update per edge: arrival only -> +1; departure only -> -1; arrival and departure together -> unchanged; neither -> unchanged.
REQ-022 Arrival at QMAX with no departure that cycle -> queue SHALL hold QMAX and the overflow bit for that street SHALL be set.
REQ-023 The queue SHALL never underflow; departure SHALL only be possible when the queue is non-zero (REQ-019).
REQ-024 Ta SHALL equal (qa_count != 0) and Tb SHALL equal (qb_count != 0), decoded from registers. Arrival to Ta high is 1 cycle (visible after the edge that samples arrive_a).
REQ-025 conflict SHALL set at the edge after any cycle where La != 00 and Lb != 00, including any 11 value.
REQ-026 illegal SHALL set at the edge after any cycle where La == 11 or Lb == 11.
REQ-027 clr_flags SHALL clear overflow, conflict and illegal at the next edge. If a set condition is present in the same cycle, set SHALL win.
REQ-028 clr_flags SHALL NOT affect queues or timers.
REQ-029 If La or Lb changes mid-departure-period, REQ-020 SHALL apply on that cycle; no departure is owed.

Reset
REQ-030 With reset == 0 at a rising edge, the block SHALL clear qa_count, qb_count and both timers to 0, and clear overflow to 00, conflict to 0 and illegal to 0. Ta and Tb SHALL then read 0.
REQ-031 Reset SHALL take priority over arrivals, departures and flag setting in the same cycle.
REQ-032 Reset asserted mid-departure SHALL discard the timer with no departure. Operation SHALL resume on the first edge with reset == 1.

Verification
REQ-033 Reset, then pulse arrive_a on 3 consecutive cycles with La=00 -> qa_count 1,2,3; Ta=1 from the cycle after the first pulse; Tb=0.
REQ-034 qa_count=3, set La=10 (DEPART_CYC=3) and hold -> qa_count decrements at the 3rd, 6th and 9th GREEN edges to 2,1,0; Ta falls after the last decrement.
REQ-035 qb_count=2, Lb=10 for 2 cycles, then 01 for 1 cycle, then 10 again -> no departure until 3 further GREEN cycles; qb_count becomes 1.
REQ-036 qa_count=15, arrive_a pulse with La=00 -> qa_count stays 15 and overflow=01. A pulse with clr_flags -> overflow=00.
REQ-037 La=10 and Lb=01 for one cycle -> conflict=1 and stays 1. La=11 for one cycle -> illegal=1. clr_flags together with La=11 -> illegal stays 1.
REQ-038 qa_count=1, timer at 1, reset low for one edge with arrive_a=1 -> qa_count=0, Ta=0, flags 0; a later arrive_a gives qa_count=1.
